alien_fleet: RTL and testbench

- Owns the invader grid: alive bitmap, fleet march (right/left/step-down), laser-vs-alien collision and per-pixel alien colour.
- Sits directly upstream of the laser stage. It consumes the laser's xLaser/yLaser and produces the killingAlien pulse the laser uses to destroy itself.
- Also feeds the pixel mixer (colorAlien) and game control (fleetCleared, invaded).

---
 rtl/space_invaders_pkg.sv | 36 +++
 rtl/fleet_extent.sv | 44 ++++
 rtl/alien_fleet.sv | 166 ++++++++++++++++
 tb/tb_alien_fleet.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/space_invaders_pkg.sv
// Shared constants, colour codes and march-state encoding for the invader fleet.
package space_invaders_pkg;

  localparam int ROWS          = 4;
  localparam int COLS          = 8;
  localparam int CELLS         = ROWS * COLS;
  localparam int ROW_W         = 2;
  localparam int COL_W         = 3;
  localparam int IDX_W         = 5;
  localparam int CNT_W         = 6;

  localparam int ALIEN_W       = 40;
  localparam int ALIEN_H       = 20;
  localparam int H_PITCH       = 60;
  localparam int V_PITCH       = 35;
  localparam int START_X       = 40;
  localparam int START_Y       = 40;
  localparam int STEP_X        = 1;
  localparam int STEP_Y        = 10;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int INVADE_Y      = 400;

  localparam logic [2:0] BACKGROUND = 3'd0;
  localparam logic [2:0] LASER      = 3'd1;
  localparam logic [2:0] ALIEN      = 3'd2;

  typedef enum logic [2:0] {
    MOVE_RIGHT,
    MOVE_LEFT,
    STEP_DOWN,
    CLEARED,
    INVADED
  } march_state_t;

endpackage

// File: rtl/fleet_extent.sv
// Combinational extents of the live fleet: leftmost/rightmost live column and lowest live row.
module fleet_extent
  import space_invaders_pkg::*;
(
  input  logic [CELLS-1:0] alive,
  output logic [COL_W-1:0] minAliveCol,
  output logic [COL_W-1:0] maxAliveCol,
  output logic [ROW_W-1:0] maxAliveRow
);

  logic [COLS-1:0] col_alive;
  logic [ROWS-1:0] row_alive;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      logic [ROWS-1:0] col_bits;
      for (genvar gr = 0; gr < ROWS; gr++) begin : g_bit
        assign col_bits[gr] = alive[gr*COLS + gi];
      end
      assign col_alive[gi] = |col_bits;
    end
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign row_alive[gi] = |alive[gi*COLS +: COLS];
    end
  endgenerate

  // Priority scans; an empty fleet reports zero extents.
  always_comb begin
    minAliveCol = '0;
    maxAliveCol = '0;
    maxAliveRow = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_alive[c]) minAliveCol = COL_W'(c);
    end
    for (int c = 0; c < COLS; c++) begin
      if (col_alive[c]) maxAliveCol = COL_W'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (row_alive[r]) maxAliveRow = ROW_W'(r);
    end
  end

endmodule

// File: rtl/alien_fleet.sv
// Invader grid: alive bitmap, fleet march, laser collision scan and per-pixel alien colour.
module alien_fleet
  import space_invaders_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] xLaser,
  input  logic [9:0] yLaser,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  output logic       killingAlien,
  output logic [2:0] colorAlien,
  output logic [5:0] aliveCount,
  output logic [9:0] fleetX,
  output logic [9:0] fleetY,
  output logic       fleetCleared,
  output logic       invaded
);

  march_state_t     state_q, state_d;
  logic             dir_left_q, dir_left_d;
  logic [9:0]       fleet_x_q, fleet_x_d;
  logic [9:0]       fleet_y_q, fleet_y_d;
  logic [CELLS-1:0] alive_q, alive_d;
  logic [CNT_W-1:0] alive_cnt_q, alive_cnt_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic             hit_wait_q, hit_wait_d;
  logic             kill_q, kill_d;
  logic [2:0]       color_q, color_d;

  logic [CELLS-1:0] pix_in, laser_in;
  logic [COL_W-1:0] min_col, max_col;
  logic [ROW_W-1:0] max_row;
  logic [10:0]      right_edge, left_edge, bottom_edge;
  logic             terminal, scan_en, hit;

  fleet_extent u_extent (
    .alive       (alive_q),
    .minAliveCol (min_col),
    .maxAliveCol (max_col),
    .maxAliveRow (max_row)
  );

  // One box compare per cell for both the pixel and the laser; offsets are constants.
  genvar gi;
  generate
    for (gi = 0; gi < CELLS; gi++) begin : g_cell
      logic [10:0] x_lo, x_hi, y_lo, y_hi;
      assign x_lo = {1'b0, fleet_x_q} + 11'((gi % COLS) * H_PITCH);
      assign x_hi = x_lo + 11'(ALIEN_W - 1);
      assign y_lo = {1'b0, fleet_y_q} + 11'((gi / COLS) * V_PITCH);
      assign y_hi = y_lo + 11'(ALIEN_H - 1);
      assign pix_in[gi] = alive_q[gi] &&
                          ({1'b0, hPos} >= x_lo) && ({1'b0, hPos} <= x_hi) &&
                          ({1'b0, vPos} >= y_lo) && ({1'b0, vPos} <= y_hi);
      assign laser_in[gi] = ({1'b0, xLaser} >= x_lo) && ({1'b0, xLaser} <= x_hi) &&
                            ({1'b0, yLaser} >= y_lo) && ({1'b0, yLaser} <= y_hi);
    end
  endgenerate

  assign right_edge  = {1'b0, fleet_x_q} + 11'(max_col) * 11'(H_PITCH) + 11'(ALIEN_W - 1);
  assign left_edge   = {1'b0, fleet_x_q} + 11'(min_col) * 11'(H_PITCH);
  assign bottom_edge = {1'b0, fleet_y_q} + 11'(max_row) * 11'(V_PITCH) + 11'(ALIEN_H - 1);

  assign terminal = (state_q == CLEARED) || (state_q == INVADED);
  assign scan_en  = (yLaser != 10'd0) && !hit_wait_q && !terminal;
  assign hit      = scan_en && alive_q[scan_idx_q] && laser_in[scan_idx_q];

  // Collision scan, bitmap update and pixel colour.
  always_comb begin
    alive_d     = alive_q;
    alive_cnt_d = alive_cnt_q;
    scan_idx_d  = '0;
    hit_wait_d  = hit_wait_q;
    kill_d      = 1'b0;
    color_d     = (|pix_in) ? ALIEN : BACKGROUND;
    if (scan_en) begin
      if (hit) begin
        alive_d[scan_idx_q] = 1'b0;
        alive_cnt_d         = alive_cnt_q - CNT_W'(1);
        kill_d              = 1'b1;
        hit_wait_d          = 1'b1;
      end else if (scan_idx_q != IDX_W'(CELLS - 1)) begin
        scan_idx_d = scan_idx_q + IDX_W'(1);
      end
    end
    // A laser must vanish before it may score again.
    if (yLaser == 10'd0) hit_wait_d = 1'b0;
  end

  // March state machine; extents come from the pre-hit bitmap.
  always_comb begin
    state_d    = state_q;
    dir_left_d = dir_left_q;
    fleet_x_d  = fleet_x_q;
    fleet_y_d  = fleet_y_q;
    if (!terminal) begin
      if (hit && (alive_cnt_q == CNT_W'(1))) begin
        state_d = CLEARED;
      end else if (bottom_edge >= 11'(INVADE_Y)) begin
        state_d = INVADED;
      end else if (enable) begin
        case (state_q)
          MOVE_RIGHT: begin
            if (right_edge + 11'(STEP_X) <= 11'(SCREEN_WIDTH - 1)) begin
              fleet_x_d = fleet_x_q + 10'(STEP_X);
            end else begin
              state_d    = STEP_DOWN;
              dir_left_d = 1'b1;
            end
          end
          MOVE_LEFT: begin
            if (left_edge >= 11'(STEP_X)) begin
              fleet_x_d = fleet_x_q - 10'(STEP_X);
            end else begin
              state_d    = STEP_DOWN;
              dir_left_d = 1'b0;
            end
          end
          STEP_DOWN: begin
            fleet_y_d = fleet_y_q + 10'(STEP_Y);
            state_d   = dir_left_q ? MOVE_LEFT : MOVE_RIGHT;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  // State register with synchronous reset to the starting formation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MOVE_RIGHT;
      dir_left_q  <= 1'b0;
      fleet_x_q   <= 10'(START_X);
      fleet_y_q   <= 10'(START_Y);
      alive_q     <= '1;
      alive_cnt_q <= CNT_W'(CELLS);
      scan_idx_q  <= '0;
      hit_wait_q  <= 1'b0;
      kill_q      <= 1'b0;
      color_q     <= BACKGROUND;
    end else begin
      state_q     <= state_d;
      dir_left_q  <= dir_left_d;
      fleet_x_q   <= fleet_x_d;
      fleet_y_q   <= fleet_y_d;
      alive_q     <= alive_d;
      alive_cnt_q <= alive_cnt_d;
      scan_idx_q  <= scan_idx_d;
      hit_wait_q  <= hit_wait_d;
      kill_q      <= kill_d;
      color_q     <= color_d;
    end
  end

  assign killingAlien = kill_q;
  assign colorAlien   = color_q;
  assign aliveCount   = alive_cnt_q;
  assign fleetX       = fleet_x_q;
  assign fleetY       = fleet_y_q;
  assign fleetCleared = (state_q == CLEARED);
  assign invaded      = (state_q == INVADED);

endmodule

// File: tb/tb_alien_fleet.sv
// Bench for alien_fleet: behavioural grid model checked every cycle plus directed literal checks.
module tb_alien_fleet;

  localparam int ST_R = 0, ST_L = 1, ST_D = 2, ST_C = 3, ST_I = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [9:0] xLaser = '0, yLaser = '0, hPos = '0, vPos = '0;
  logic       killingAlien;
  logic [2:0] colorAlien;
  logic [5:0] aliveCount;
  logic [9:0] fleetX, fleetY;
  logic       fleetCleared, invaded;

  int checks = 0;
  int failures = 0;

  alien_fleet dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .xLaser       (xLaser),
    .yLaser       (yLaser),
    .hPos         (hPos),
    .vPos         (vPos),
    .killingAlien (killingAlien),
    .colorAlien   (colorAlien),
    .aliveCount   (aliveCount),
    .fleetX       (fleetX),
    .fleetY       (fleetY),
    .fleetCleared (fleetCleared),
    .invaded      (invaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_box(input int r, input int c, input int x, input int y,
                                input int fx, input int fy);
    return (x >= fx + c*60) && (x <= fx + c*60 + 39) &&
           (y >= fy + r*35) && (y <= fy + r*35 + 19);
  endfunction

  // ---------------- behavioural model ----------------
  bit m_alive[4][8];
  int m_fx, m_fy, m_state, m_dir, m_idx, m_wait, m_kill, m_color;
  bit m_valid = 1'b0;

  always @(posedge clk) begin : model_step
    int n_fx, n_fy, n_state, n_dir, n_idx, n_wait, n_kill, n_color;
    int cnt, minc, maxc, maxr, ri, ci;
    bit hit;
    bit n_alive[4][8];
    if (reset) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 8; c++) m_alive[r][c] <= 1'b1;
      m_fx <= 40; m_fy <= 40; m_state <= ST_R; m_dir <= 0;
      m_idx <= 0; m_wait <= 0; m_kill <= 0; m_color <= 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      n_alive = m_alive;
      n_fx = m_fx; n_fy = m_fy; n_state = m_state; n_dir = m_dir;
      n_wait = m_wait; n_kill = 0; n_color = 0; n_idx = 0;
      cnt = 0; minc = 8; maxc = -1; maxr = -1;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 8; c++) begin
          if (m_alive[r][c]) begin
            cnt++;
            if (c < minc) minc = c;
            if (c > maxc) maxc = c;
            if (r > maxr) maxr = r;
            if (in_box(r, c, hPos, vPos, m_fx, m_fy)) n_color = 2;
          end
        end
      end
      if (cnt == 0) begin minc = 0; maxc = 0; maxr = 0; end
      hit = 1'b0;
      if (yLaser != 0 && m_wait == 0 && m_state < ST_C) begin
        ri = m_idx / 8; ci = m_idx % 8;
        if (m_alive[ri][ci] && in_box(ri, ci, xLaser, yLaser, m_fx, m_fy)) begin
          hit = 1'b1; n_alive[ri][ci] = 1'b0; n_kill = 1; n_wait = 1;
        end else begin
          n_idx = (m_idx + 1) % 32;
        end
      end
      if (yLaser == 0) n_wait = 0;
      if (m_state < ST_C) begin
        if (hit && cnt == 1) n_state = ST_C;
        else if (m_fy + maxr*35 + 19 >= 400) n_state = ST_I;
        else if (enable) begin
          if (m_state == ST_R) begin
            if (m_fx + maxc*60 + 39 + 1 <= 639) n_fx = m_fx + 1;
            else begin n_state = ST_D; n_dir = 1; end
          end else if (m_state == ST_L) begin
            if (m_fx + minc*60 >= 1) n_fx = m_fx - 1;
            else begin n_state = ST_D; n_dir = 0; end
          end else begin
            n_fy = m_fy + 10;
            n_state = (m_dir == 1) ? ST_L : ST_R;
          end
        end
      end
      m_alive <= n_alive;
      m_fx <= n_fx; m_fy <= n_fy; m_state <= n_state; m_dir <= n_dir;
      m_idx <= n_idx; m_wait <= n_wait; m_kill <= n_kill; m_color <= n_color;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    int cnt;
    if (m_valid) begin
      cnt = 0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 8; c++) cnt += m_alive[r][c];
      check("cyc_kill", killingAlien, m_kill);
      check("cyc_color", colorAlien, m_color);
      check("cyc_count", aliveCount, cnt);
      check("cyc_fleetX", fleetX, m_fx);
      check("cyc_fleetY", fleetY, m_fy);
      check("cyc_cleared", fleetCleared, m_state == ST_C);
      check("cyc_invaded", invaded, m_state == ST_I);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      enable = 1'b1; step();
      enable = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; xLaser = '0; yLaser = '0; hPos = '0; vPos = '0;
    step(); step();
    reset = 1'b0;
    $display("reset applied");
  endtask

  task automatic kill_cell(input int r, input int c);
    int got;
    got = 0;
    xLaser = 10'(fleetX + c*60 + 20);
    yLaser = 10'(fleetY + r*35 + 10);
    for (int k = 0; k < 40 && got == 0; k++) begin
      step();
      if (killingAlien) got = 1;
    end
    xLaser = '0; yLaser = '0;
    step(); step();
    check("kill_seen", got, 1);
    $display("kill cell (%0d,%0d) seen=%0d aliveCount=%0d", r, c, got, aliveCount);
  endtask

  initial begin
    int npulse, first_k, done;

    do_reset();
    check("rst_count", aliveCount, 32);
    check("rst_fleetX", fleetX, 40);
    check("rst_fleetY", fleetY, 40);
    check("rst_kill", killingAlien, 0);
    check("rst_color", colorAlien, 0);
    check("rst_cleared", fleetCleared, 0);
    check("rst_invaded", invaded, 0);

    hPos = 45; vPos = 45; step();
    check("pix_inside", colorAlien, 2);
    $display("pixel (45,45) color=%0d", colorAlien);
    hPos = 85; step();
    check("pix_gap", colorAlien, 0);
    $display("pixel (85,45) color=%0d", colorAlien);

    xLaser = 85; yLaser = 50; npulse = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (killingAlien) npulse++;
    end
    xLaser = 0; yLaser = 0; step();
    check("gap_no_kill", npulse, 0);
    check("gap_count", aliveCount, 32);
    $display("gap laser (85,50) pulses=%0d", npulse);

    xLaser = 60; yLaser = 50; npulse = 0; first_k = -1;
    for (int k = 1; k <= 133; k++) begin
      step();
      if (killingAlien) begin
        npulse++;
        if (first_k < 0) first_k = k;
      end
    end
    check("hit_one_pulse", npulse, 1);
    check("hit_latency_ok", (first_k >= 1 && first_k <= 33) ? 1 : 0, 1);
    check("hit_count", aliveCount, 31);
    $display("laser (60,50) pulses=%0d first=%0d aliveCount=%0d", npulse, first_k, aliveCount);
    xLaser = 0; yLaser = 0; hPos = 45; vPos = 45; step();
    check("pix_dead", colorAlien, 0);
    $display("pixel (45,45) after kill color=%0d", colorAlien);

    do_reset();
    pulses(140);
    check("march140_x", fleetX, 180);
    check("march140_y", fleetY, 40);
    pulses(1);
    check("march141_x", fleetX, 180);
    check("march141_y", fleetY, 40);
    pulses(1);
    check("march142_y", fleetY, 50);
    check("march142_x", fleetX, 180);
    pulses(1);
    check("march143_x", fleetX, 179);
    $display("march: fleetX=%0d fleetY=%0d", fleetX, fleetY);

    do_reset();
    for (int r = 0; r < 4; r++) kill_cell(r, 7);
    pulses(200);
    check("ext200_x", fleetX, 240);
    pulses(1);
    check("ext201_x", fleetX, 240);
    check("ext201_y", fleetY, 40);
    pulses(1);
    check("ext202_y", fleetY, 50);
    pulses(1);
    check("ext203_x", fleetX, 239);
    $display("extent march: fleetX=%0d fleetY=%0d", fleetX, fleetY);

    do_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) kill_cell(r, c);
    check("clr_flag", fleetCleared, 1);
    check("clr_count", aliveCount, 0);
    pulses(10);
    check("clr_frozen_x", fleetX, 40);
    check("clr_still", fleetCleared, 1);
    do_reset();
    check("clr_rst_flag", fleetCleared, 0);
    check("clr_rst_count", aliveCount, 32);
    $display("cleared test done");

    done = 0;
    for (int i = 0; i < 5000 && done == 0; i++) begin
      pulses(1);
      if (invaded) done = 1;
    end
    check("inv_flag", invaded, 1);
    check("inv_fleetY", fleetY, 280);
    npulse = fleetX;
    pulses(5);
    check("inv_frozen_x", fleetX, npulse);
    check("inv_frozen_y", fleetY, 280);
    $display("invaded: fleetX=%0d fleetY=%0d", fleetX, fleetY);
    do_reset();
    check("inv_rst_flag", invaded, 0);
    check("inv_rst_x", fleetX, 40);
    check("inv_rst_y", fleetY, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
